// File: rtl/dino_tick_pkg.sv
// Shared definitions for the game tick scheduler.
//
// Contents:
//   run_state_e  game run-state encoding (ST_IDLE, ST_RUN, ST_PAUSE, ST_OVER)
//   clog2        ceil(log2(value)), never less than 1; used to size counters
//   max_level    number of speed levels above level 0 that the obstacle period
//                can take before it would drop below the minimum period
//
// No ports (package).
package dino_tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } run_state_e;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned n;
    n = 0;
    while ((64'd1 << n) < value) n++;
    return (n == 0) ? 1 : n;
  endfunction

  // A zero step would mean an unbounded number of levels; report 0 and let
  // the elaboration check in the top flag the bad configuration.
  function automatic int unsigned max_level(input int unsigned base_div,
                                            input int unsigned min_div,
                                            input int unsigned step_div);
    if (step_div == 0 || min_div > base_div) return 0;
    return (base_div - min_div) / step_div;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Clock-enable divider: emits a one-cycle registered strobe every div_i
// enabled cycles.
//
// The counter runs 0..div-1. On the enabled cycle where it sits at div-1 it
// returns to 0 and the tick register is set for exactly one cycle. The period
// in use is held in div_q and only reloaded from div_i when the counter wraps
// or is cleared, so a change on div_i never shortens a count in progress.
//
// Parameters:
//   W       counter / period width (must hold the largest div_i value)
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset (counter 0, tick 0, period <= div_i)
//   en_i    advance the counter this cycle
//   clr_i   restart: counter 0, tick 0, period <= div_i (beats en_i)
//   div_i   period in cycles, >= 1
//   tick_o  registered one-cycle strobe
module tick_divider #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] div_q, div_d;
  logic         tick_q, tick_d;
  logic         wrap;

  always_comb begin
    wrap   = en_i && (cnt_q == (div_q - W'(1)));
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
      div_d = div_i;
    end else if (wrap) begin
      cnt_d  = '0;
      div_d  = div_i;
      tick_d = 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      div_q  <= div_i;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game tick scheduler: replaces derived game clocks with one-cycle clock
// enables on clk50MHz and owns the game run-state machine.
//
//   score_tick  every SCORE_DIV cycles, RUN only
//   frame_tick  every FRAME_DIV cycles, free-running after reset
//   obst_tick   every obstacle period, RUN only; the period shrinks as the
//               speed level rises
//
// Build option: define SPEEDUP_EN to enable the speed ramp (speed_level
// advances every SCORE_PER_LEVEL score ticks, saturating at MAX_LEVEL).
// Without it speed_level is 0 and the obstacle period is fixed at
// OBST_BASE_DIV.
//
// Ports:
//   clk50MHz     in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   start        in   1  pulse: begin / restart a game (IDLE or OVER)
//   pause        in   1  pulse: toggle RUN <-> PAUSE
//   collision    in   1  pulse: dino hit an obstacle (RUN or PAUSE -> OVER)
//   state        out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 OVER
//   score_tick   out  1  one-cycle strobe
//   frame_tick   out  1  one-cycle strobe
//   obst_tick    out  1  one-cycle strobe
//   speed_level  out  4  current speed level, 0..MAX_LEVEL
module game_tick_scheduler
  import dino_tick_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned SCORE_HZ        = 10,
  parameter int unsigned FRAME_HZ        = 60,
  parameter int unsigned OBST_BASE_DIV   = 500_000,
  parameter int unsigned OBST_MIN_DIV    = 200_000,
  parameter int unsigned SPEED_STEP_DIV  = 25_000,
  parameter int unsigned SCORE_PER_LEVEL = 100
) (
  input  logic       clk50MHz,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       collision,
  output logic [1:0] state,
  output logic       score_tick,
  output logic       frame_tick,
  output logic       obst_tick,
  output logic [3:0] speed_level
);

  localparam int unsigned SCORE_DIV  = CLK_HZ / SCORE_HZ;
  localparam int unsigned FRAME_DIV  = CLK_HZ / FRAME_HZ;
  localparam int unsigned MAX_LEVEL  = max_level(OBST_BASE_DIV, OBST_MIN_DIV, SPEED_STEP_DIV);
  // Dividers must hold the period value itself, hence clog2(div + 1).
  localparam int unsigned SCORE_W    = clog2(SCORE_DIV + 1);
  localparam int unsigned FRAME_W    = clog2(FRAME_DIV + 1);
  localparam int unsigned OBST_RAW_W = clog2(OBST_BASE_DIV + 1);
  localparam int unsigned OBST_W     = (OBST_RAW_W < 20) ? 20 : OBST_RAW_W;

  if (MAX_LEVEL > 15) begin : g_bad_max_level
    $error("game_tick_scheduler: MAX_LEVEL exceeds the 4-bit speed_level range");
  end
  if (SPEED_STEP_DIV == 0 || SCORE_PER_LEVEL == 0 || SCORE_DIV == 0 ||
      FRAME_DIV == 0 || OBST_MIN_DIV == 0 || OBST_MIN_DIV > OBST_BASE_DIV) begin : g_bad_cfg
    $error("game_tick_scheduler: invalid divider configuration");
  end

  run_state_e state_q, state_d;
  logic       run_entry;
  logic       run_hold;
  logic [3:0] level_q;
  logic [OBST_W-1:0] obst_div;

  // ---- run-state machine: collision > pause > start ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (collision)  state_d = ST_OVER;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (collision)  state_d = ST_OVER;
        else if (pause) state_d = ST_RUN;
      end
      ST_OVER:  if (start) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50MHz) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A fresh game (from IDLE or OVER) restarts every game counter; resuming
  // from PAUSE does not. The game dividers only advance on cycles that both
  // start and end in RUN, so no tick is registered on the cycle that leaves
  // RUN and a paused count resumes exactly where it stopped.
  assign run_entry = (state_d == ST_RUN) && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  assign run_hold  = (state_q == ST_RUN) && (state_d == ST_RUN);

  // ---- speed ramp ----
`ifdef SPEEDUP_EN
  localparam int unsigned LVL_W = clog2(SCORE_PER_LEVEL);

  logic [LVL_W-1:0] level_cnt_q, level_cnt_d;
  logic [3:0]       level_d;

  // Counts registered score ticks; the level moves one cycle after the
  // SCORE_PER_LEVEL-th tick is visible on score_tick.
  always_comb begin
    level_cnt_d = level_cnt_q;
    level_d     = level_q;
    if (run_entry) begin
      level_cnt_d = '0;
      level_d     = '0;
    end else if (score_tick) begin
      if (level_cnt_q == LVL_W'(SCORE_PER_LEVEL - 1)) begin
        level_cnt_d = '0;
        if (level_q != 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
      end else begin
        level_cnt_d = level_cnt_q + LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk50MHz) begin
    if (reset) begin
      level_cnt_q <= '0;
      level_q     <= '0;
    end else begin
      level_cnt_q <= level_cnt_d;
      level_q     <= level_d;
    end
  end

  // On a fresh game the level is being cleared this same cycle, so load the
  // base period directly rather than the stale level's period.
  always_comb begin
    if (run_entry) obst_div = OBST_W'(OBST_BASE_DIV);
    else           obst_div = OBST_W'(OBST_BASE_DIV) - (OBST_W'(level_q) * OBST_W'(SPEED_STEP_DIV));
  end
`else
  assign level_q  = 4'd0;
  assign obst_div = OBST_W'(OBST_BASE_DIV);
`endif

  // ---- tick dividers ----
  tick_divider #(.W(SCORE_W)) u_score_div (
    .clk_i  (clk50MHz),
    .rst_i  (reset),
    .en_i   (run_hold),
    .clr_i  (run_entry),
    .div_i  (SCORE_W'(SCORE_DIV)),
    .tick_o (score_tick)
  );

  tick_divider #(.W(FRAME_W)) u_frame_div (
    .clk_i  (clk50MHz),
    .rst_i  (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .div_i  (FRAME_W'(FRAME_DIV)),
    .tick_o (frame_tick)
  );

  tick_divider #(.W(OBST_W)) u_obst_div (
    .clk_i  (clk50MHz),
    .rst_i  (reset),
    .en_i   (run_hold),
    .clr_i  (run_entry),
    .div_i  (obst_div),
    .tick_o (obst_tick)
  );

  assign state       = state_q;
  assign speed_level = level_q;

endmodule
